// File: rtl/iface_reg_channel_pkg.sv
// Shared constants and data type for the registered point-to-point channel.
package iface_reg_channel_pkg;

  localparam int unsigned DATA_W_DEFAULT = 32;
  localparam int unsigned MAX_LATENCY    = 8;

  typedef logic [DATA_W_DEFAULT-1:0] data_t;

endpackage

// File: rtl/iface_reg_stage.sv
// One pipeline register of the channel: async active-low clear, hold when not enabled.
module iface_reg_stage
  import iface_reg_channel_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/iface_reg_channel.sv
// Fixed-latency registered channel: LATENCY enabled stages from d to q, with a
// saturating fill counter that flags when q holds a word captured since reset.
module iface_reg_channel
  import iface_reg_channel_pkg::*;
#(
  parameter int unsigned WIDTH   = DATA_W_DEFAULT,
  parameter int unsigned LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  localparam int unsigned FILL_W = $clog2(LATENCY + 1);

  if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_latency_check
    $error("iface_reg_channel: LATENCY must be in 1..8");
  end

  // chain[0] is the producer word; chain[i+1] is the output of stage i.
  logic [LATENCY:0][WIDTH-1:0] chain;

  assign chain[0] = d;

  for (genvar i = 0; i < LATENCY; i++) begin : g_stage
    iface_reg_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .d     (chain[i]),
      .q     (chain[i+1])
    );
  end

  assign q = chain[LATENCY];

  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_nxt;

  // Count enabled edges since reset, saturating once the pipe is full.
  always_comb begin
    fill_nxt = fill;
    if (en && (fill != FILL_W'(LATENCY))) begin
      fill_nxt = fill + FILL_W'(1);
    end
  end

  // q_valid is registered alongside fill so it rises with the first word on q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill    <= '0;
      q_valid <= 1'b0;
    end else begin
      fill    <= fill_nxt;
      q_valid <= (fill_nxt == FILL_W'(LATENCY));
    end
  end

endmodule

// File: tb/tb_iface_reg_channel.sv
// Self-checking bench for iface_reg_channel at LATENCY 1, 2 and 3 sharing one stimulus.
module tb_iface_reg_channel;
  import iface_reg_channel_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n;
  logic  en;
  data_t d;
  data_t q1, q2, q3;
  logic  v1, v2, v3;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboards: the last LATENCY captured words per instance, oldest first.
  data_t sb1[$];
  data_t sb2[$];
  data_t sb3[$];

  always #5 clk = ~clk;

  iface_reg_channel #(.WIDTH(32), .LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .en(en), .d(d), .q(q1), .q_valid(v1));
  iface_reg_channel #(.WIDTH(32), .LATENCY(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .en(en), .d(d), .q(q2), .q_valid(v2));
  iface_reg_channel #(.WIDTH(32), .LATENCY(3)) u_l3 (
    .clk(clk), .rst_n(rst_n), .en(en), .d(d), .q(q3), .q_valid(v3));

  function automatic data_t exp_q1();
    return (sb1.size() == 1) ? sb1[0] : '0;
  endfunction
  function automatic data_t exp_q2();
    return (sb2.size() == 2) ? sb2[0] : '0;
  endfunction
  function automatic data_t exp_q3();
    return (sb3.size() == 3) ? sb3[0] : '0;
  endfunction

  task automatic clear_sb();
    sb1.delete();
    sb2.delete();
    sb3.delete();
  endtask

  // Advance one clock edge; push the captured word and retire the oldest one.
  task automatic clk_edge();
    logic  cap;
    data_t dv;
    cap = en & rst_n;
    dv  = d;
    @(posedge clk);
    #1;
    if (cap) begin
      sb1.push_back(dv);
      sb2.push_back(dv);
      sb3.push_back(dv);
      if (sb1.size() > 1) void'(sb1.pop_front());
      if (sb2.size() > 2) void'(sb2.pop_front());
      if (sb3.size() > 3) void'(sb3.pop_front());
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_sb();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    en    = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    d     = 32'hFFFF_FFFF;
    clear_sb();
    repeat (2) clk_edge();
    n_tests++;
    if ({q1, q2, q3} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_q: got %h %h %h expected 0", q1, q2, q3);
    end
    n_tests++;
    if ({v1, v2, v3} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_valid: got %b%b%b expected 000", v1, v2, v3);
    end
    rst_n = 1'b1;
    clk_edge();
    n_tests++;
    if (q1 !== 32'hFFFF_FFFF || v1 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_capture: got q=%h v=%b expected ffffffff 1", q1, v1);
    end
    #3;
    rst_n = 1'b0;
    clear_sb();
    #1;
    n_tests++;
    if (q1 !== 32'h0 || v1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: got q=%h v=%b expected 0 0", q1, v1);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    apply_reset();
    for (int i = 0; i < 100; i++) begin
      d = 32'(i);
      clk_edge();
      n_tests++;
      if (q1 !== 32'(i) || v1 !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_l1[%0d]: got q=%h v=%b expected %h 1", i, q1, v1, 32'(i));
      end
      n_tests++;
      if (q2 !== ((i >= 1) ? 32'(i - 1) : 32'h0) || v2 !== (i >= 1)) begin
        n_fail++;
        $display("FAIL stream_l2[%0d]: got q=%h v=%b", i, q2, v2);
      end
    end
  endtask

  task automatic test_latency3();
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      d = 32'(i);
      clk_edge();
      n_tests++;
      if (v3 !== (i >= 2)) begin
        n_fail++;
        $display("FAIL lat3_valid[%0d]: got %b expected %b", i, v3, (i >= 2));
      end
      n_tests++;
      if (q3 !== ((i >= 2) ? 32'(i - 2) : 32'h0)) begin
        n_fail++;
        $display("FAIL lat3_q[%0d]: got %h expected %h", i, q3,
                 (i >= 2) ? 32'(i - 2) : 32'h0);
      end
    end
  endtask

  task automatic test_stall();
    logic [5:0] en_pat;
    int         n_en;
    apply_reset();
    d = 32'd5;
    clk_edge();
    n_tests++;
    if (q1 !== 32'd5) begin
      n_fail++;
      $display("FAIL stall_setup: got %h expected 5", q1);
    end
    en = 1'b0;
    d  = 32'd9;
    for (int k = 0; k < 4; k++) begin
      clk_edge();
      n_tests++;
      if (q1 !== 32'd5 || v1 !== 1'b1 || q3 !== exp_q3()) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got q1=%h v1=%b q3=%h expected 5 1 %h",
                 k, q1, v1, q3, exp_q3());
      end
    end
    en = 1'b1;
    clk_edge();
    n_tests++;
    if (q1 !== 32'd9) begin
      n_fail++;
      $display("FAIL stall_resume: got %h expected 9", q1);
    end
    // Only enabled edges advance fill.
    apply_reset();
    en_pat = 6'b101001;
    n_en   = 0;
    for (int j = 0; j < 6; j++) begin
      en = en_pat[j];
      d  = 32'(50 + j);
      clk_edge();
      if (en_pat[j]) n_en++;
      n_tests++;
      if (v3 !== (n_en >= 3) || q3 !== exp_q3()) begin
        n_fail++;
        $display("FAIL fill_toggle[%0d]: got v=%b q=%h expected %b %h",
                 j, v3, q3, (n_en >= 3), exp_q3());
      end
    end
    en = 1'b1;
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      d = 32'(100 + i);
      clk_edge();
    end
    #3;
    rst_n = 1'b0;
    clear_sb();
    #1;
    n_tests++;
    if (q2 !== 32'h0 || v2 !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_clear: got q=%h v=%b expected 0 0", q2, v2);
    end
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      d = 32'(200 + k);
      clk_edge();
      n_tests++;
      if (v2 !== (k >= 1) || q2 !== ((k >= 1) ? 32'(199 + k) : 32'h0)) begin
        n_fail++;
        $display("FAIL midreset_refill[%0d]: got q=%h v=%b", k, q2, v2);
      end
    end
  endtask

  task automatic test_integrity();
    data_t pat [6];
    pat = '{32'hAAAA_5555, 32'h8000_0001, 32'h0000_0000,
            32'hFFFF_0000, 32'h0F0F_0F0F, 32'h1234_5678};
    apply_reset();
    for (int j = 0; j < 6; j++) begin
      d = pat[j];
      clk_edge();
      n_tests++;
      if (q1 !== pat[j] || q1 !== exp_q1()) begin
        n_fail++;
        $display("FAIL integ_l1[%0d]: got %h expected %h", j, q1, pat[j]);
      end
      n_tests++;
      if (q2 !== exp_q2() || v2 !== (sb2.size() == 2)) begin
        n_fail++;
        $display("FAIL integ_l2[%0d]: got q=%h v=%b expected %h", j, q2, v2, exp_q2());
      end
      n_tests++;
      if (q3 !== exp_q3() || v3 !== (sb3.size() == 3)) begin
        n_fail++;
        $display("FAIL integ_l3[%0d]: got q=%h v=%b expected %h", j, q3, v3, exp_q3());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    d     = '0;
    test_reset();
    test_stream();
    test_latency3();
    test_stall();
    test_reset_midstream();
    test_integrity();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/iface_reg_channel.md
# iface_reg_channel

Registered point-to-point data channel between a producer and a consumer in the same clock domain. The producer drives a 32-bit data word. The channel returns that word on its output after a fixed number of clock edges. Its main use is as a shared register bundle: one agent writes `d` every cycle, and another agent samples `q` as a pipelined copy.

## Interface
Parameters:
- `WIDTH`, default 32: data word width in bits.
- `LATENCY`, default 1: number of register stages from `d` to `q`; legal range is 1..8.

Ports:
- `clk`, input, 1: single clock. All state updates on its rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `en`, input, 1: advance enable. When 1, all stages shift. When 0, all stages hold.
- `d`, input, WIDTH: producer data word.
- `q`, output, WIDTH: consumer data word, equal to `d` delayed by LATENCY enabled edges.
- `q_valid`, output, 1: high once `q` holds a word that was captured from `d` since the last reset.

## Operation
- Pipeline: the design has LATENCY register stages, s[0]..s[LATENCY-1].
  - On a rising `clk` edge with `en`=1: s[0] <= d, and s[i] <= s[i-1] for each later stage.
  - `q` = s[LATENCY-1], driven directly from the flop with no combinational path from `d`.
- Fill tracking:
  - A saturating counter `fill` (width clog2(LATENCY+1)) increments on each enabled edge until it reaches LATENCY.
  - `q_valid` = (fill == LATENCY).
- With `en`=0, stages and `fill` hold their values and `d` is ignored.
- Reset (`rst_n`=0, asynchronous):
  - All stages clear to 0 immediately, so `q`=0.
  - `fill`=0, so `q_valid`=0.
  - The clear does not wait for a clock edge.
- Reset deassertion takes effect at the next rising edge. The first edge with `rst_n`=1 and `en`=1 captures `d`.
- Width rule: the data path carries the word unchanged, with no arithmetic, truncation or sign handling.
- Reset asserted mid-stream: in-flight words are discarded. After release, `q_valid` rises again only after LATENCY enabled edges.

## Timing
- Latency is exactly LATENCY enabled rising edges from `d` to `q`. With LATENCY=1, the value of `d` present at edge k appears on `q` immediately after edge k.
- Throughput is one word per enabled cycle, with no bubbles.
- When `d` is updated at every edge with a new value (the producer writes with nonblocking semantics), a sample of `q` taken at edge k equals the `d` written at edge k-1-LATENCY. For LATENCY=1, a consumer sampling at edge N sees the value written at edge N-2.
- `q_valid` rises on the same edge that the first post-reset word reaches `q`.
- Reset values: `q`=0 and `q_valid`=0. `q` reads 0 before the first capture, not X.
- If `en` toggles during fill, only enabled edges count toward `q_valid`.

## Structure
- Shared package `iface_reg_channel_pkg` holds:
  - `DATA_W_DEFAULT`=32,
  - `MAX_LATENCY`=8,
  - typedef `data_t` = logic [DATA_W_DEFAULT-1:0].
- Sub-module `iface_reg_stage`: one WIDTH-bit flop with asynchronous active-low clear and enable.
  - The top level instantiates it LATENCY times in a generate loop.
- The fill counter and `q_valid` logic live in the top level.
- Add a parameter assertion for LATENCY in the range 1..8.

## Test plan
- Reset: hold `rst_n`=0 with `d`=32'hFFFF_FFFF -> `q`=0 and `q_valid`=0. Then assert `rst_n`=0 asynchronously mid-cycle -> `q` clears to 0 before the next edge.
- Streaming (LATENCY=1, `en`=1): at each edge write `d` <= cycle count, for 100 cycles. From cycle 2 onward, the `q` sampled at edge N must equal N-2. `q_valid`=1 from the first capture onward.
- Latency sweep: run with LATENCY=3, streaming 0,1,2,.. -> `q_valid` rises after 3 enabled edges, and `q` then follows 0,1,2 in order.
- Enable stall: with LATENCY=1 and `q`=5, drop `en` for 4 cycles while `d`=9 -> `q` stays 5. Re-enable -> `q`=9 after one edge.
- Reset mid-stream: with LATENCY=2 while streaming, pulse `rst_n` low -> `q`=0 and `q_valid`=0. After release, `q_valid` returns after 2 enabled edges, with no pre-reset data reappearing.
- Data integrity: stream the patterns 32'hAAAA_5555, 32'h8000_0001 and 32'h0 -> each appears on `q` bit-exact after LATENCY edges.
